// File: rtl/sm_to_twos_serial.sv
// -----------------------------------------------------------------------------
// sm_to_twos_serial
//
// Bit-serial sign-magnitude to two's-complement decoder. Takes an unsigned
// magnitude plus a negative flag (the output format of the RCA subtractor)
// and produces a WIDTH+1 bit signed two's-complement value. Negation is done
// with one full-adder slice (b input tied to 0) iterated LSB-first: each
// operand bit is inverted and the initial carry of 1 supplies the "+1".
//
// One transaction is held at a time:
//   IDLE  : waiting for in_valid; accepts when in_ready is high.
//   SHIFT : WIDTH+1 cycles, one result bit per clock, shifted in from the MSB.
//   DONE  : result presented with out_valid until out_ready takes it.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-high
//   in_valid   in   mag/neg valid
//   in_ready   out  block can accept an input this cycle (IDLE and not in reset)
//   mag        in   [WIDTH-1:0] unsigned magnitude
//   neg        in   1 means the value is -mag
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   result     out  [WIDTH:0] signed two's-complement value
//   busy       out  high in SHIFT or DONE
// -----------------------------------------------------------------------------
module sm_to_twos_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] mag,
  input  logic             neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             busy
);

  // Bit counter walks 0..WIDTH; sized with headroom so the compare against
  // WIDTH never depends on a wrap.
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH:0]  r_op;      // zero-extended magnitude being consumed
  logic            r_neg;     // latched sign flag for this transaction
  logic            r_carry;   // full-adder carry between serial steps
  logic [CW-1:0]   r_count;   // index of the operand bit processed this cycle
  logic [WIDTH:0]  r_result;  // result assembled from the MSB side

  logic            w_accept;
  logic            w_transfer;
  logic            w_last_bit;
  logic            w_op_bit;
  logic            w_out_bit;
  logic            w_carry_next;

  // ---------------------------------------------------------------------------
  // Handshake qualifiers
  // ---------------------------------------------------------------------------
  assign w_accept   = in_valid && in_ready;
  assign w_transfer = out_valid && out_ready;
  assign w_last_bit = (r_count == CW'(WIDTH));

  // ---------------------------------------------------------------------------
  // Serial full-adder slice with b = 0.
  // Negate: sum = ~a ^ cin, cout = ~a & cin, starting with cin = 1.
  // Pass-through: sum = a, carry ignored.
  // ---------------------------------------------------------------------------
  assign w_op_bit     = r_op[r_count];
  assign w_out_bit    = r_neg ? (~w_op_bit ^ r_carry) : w_op_bit;
  assign w_carry_next = ~w_op_bit & r_carry;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of every always_comb keeps each
  // path fully specified, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (w_last_bit) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (w_transfer) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (Moore, decoded from the state register)
  // in_ready also masks with rst so nothing is advertised during reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = !rst;
      end
      SHIFT: begin
        busy = 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  assign result = r_result;

  // ---------------------------------------------------------------------------
  // Datapath
  // Every datapath register is cleared by reset so an aborted transaction
  // leaves no residue in the operand, carry, count or result.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_carry  <= 1'b0;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          // result is left untouched here: it keeps the last value until the
          // next SHIFT starts overwriting it.
          if (w_accept) begin
            r_op    <= {1'b0, mag};
            r_neg   <= neg;
            r_carry <= 1'b1;
            r_count <= '0;
          end
        end
        SHIFT: begin
          // Shift right so the first (LSB) bit ends up at result[0] after
          // WIDTH+1 steps. The carry out of the final step is dropped.
          r_result <= {w_out_bit, r_result[WIDTH:1]};
          r_carry  <= w_carry_next;
          if (!w_last_bit) begin
            r_count <= r_count + CW'(1);
          end
        end
        DONE: begin
          // Hold everything stable while the consumer back-pressures.
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_to_twos_serial.sv
// -----------------------------------------------------------------------------
// tb_sm_to_twos_serial
//
// Directed bench for sm_to_twos_serial (WIDTH=4). Inputs are driven on the
// falling edge, outputs are sampled on the falling edge or 1 time unit after
// the rising edge. Expected values are hand-computed constants, plus a plain
// arithmetic negation for the full sweep.
// -----------------------------------------------------------------------------
module tb_sm_to_twos_serial;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] mag;
  logic             neg;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   result;
  logic             busy;

  int checks;
  int errors;

  sm_to_twos_serial #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mag       (mag),
    .neg       (neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one input at the falling edge and hold it through the accepting
  // rising edge (E0). Returns 1 time unit after E0.
  task automatic send(input logic [WIDTH-1:0] m, input logic n);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("send_in_ready", {31'd0, in_ready}, 32'd1);
    mag      = m;
    neg      = n;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Accept, check latency/result, then transfer with out_ready high.
  task automatic run_txn(input string tag, input logic [WIDTH-1:0] m, input logic n,
                         input logic [WIDTH:0] exp);
    send(m, n);
    repeat (WIDTH) @(posedge clk);
    #1;
    check({tag, "_early_valid"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_result"}, {27'd0, result}, {27'd0, exp});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [WIDTH:0] held;
    logic [WIDTH:0] exp5;
    logic           got;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    mag       = '0;
    neg       = 1'b0;
    out_ready = 1'b0;

    // ---- reset state ------------------------------------------------------
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", {27'd0, result}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ---- mag=5 neg=0 with detailed timing ---------------------------------
    out_ready = 1'b1;
    send(4'd5, 1'b0);
    check("t1_in_ready_drop", {31'd0, in_ready}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    repeat (WIDTH) @(posedge clk);
    #1;
    check("t1_valid_at_e4", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("t1_valid_at_e5", {31'd0, out_valid}, 32'd1);
    check("t1_result", {27'd0, result}, 32'h05);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("t1_valid_drop", {31'd0, out_valid}, 32'd0);
    check("t1_in_ready_back", {31'd0, in_ready}, 32'd1);

    // ---- negations and boundaries -----------------------------------------
    run_txn("neg5", 4'd5, 1'b1, 5'b11011);
    run_txn("neg15", 4'd15, 1'b1, 5'b10001);
    run_txn("negzero", 4'd0, 1'b1, 5'b00000);
    run_txn("poszero", 4'd0, 1'b0, 5'b00000);
    run_txn("pos15", 4'd15, 1'b0, 5'b01111);

    // ---- backpressure -----------------------------------------------------
    send(4'd6, 1'b1);
    repeat (WIDTH + 1) @(posedge clk);
    #1;
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    check("bp_result", {27'd0, result}, 32'h1A);
    held     = result;
    mag      = 4'd3;
    neg      = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_result", {27'd0, result}, {27'd0, held});
      check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp_xfer_valid", {31'd0, out_valid}, 32'd0);
    check("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_idle_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check("bp_ignored_input", {31'd0, busy}, 32'd0);

    // ---- async reset mid-SHIFT --------------------------------------------
    send(4'd5, 1'b1);
    repeat (2) @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_result", {27'd0, result}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_release_in_ready", {31'd0, in_ready}, 32'd1);
    run_txn("after_rst_neg9", 4'd9, 1'b1, 5'b10111);

    // ---- full sweep with random backpressure ------------------------------
    for (int k = 0; k < 32; k++) begin
      send(k[3:0], k[4]);
      exp5 = k[4] ? 5'(5'd0 - {1'b0, k[3:0]}) : {1'b0, k[3:0]};
      got  = 1'b0;
      for (int c = 0; c < 60 && !got; c++) begin
        @(negedge clk);
        out_ready = 1'($urandom_range(0, 1));
        #1;
        if (out_valid && out_ready) begin
          got = 1'b1;
          check($sformatf("sweep_%0d_result", k), {27'd0, result}, {27'd0, exp5});
          @(posedge clk);
          #1;
          out_ready = 1'b0;
        end
      end
      check($sformatf("sweep_%0d_done", k), {31'd0, got}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm_to_twos_serial.md
Name: sm_to_twos_serial

Overview:
- Bit-serial decoder that turns a magnitude plus negative-flag pair (the format our RCA-based subtractor produces) back into a signed two's-complement value.
- Uses a single full-adder slice, iterated LSB-first, to negate the magnitude when required.
- Sits downstream of the subtractor and feeds signed consumers.
- Uses valid/ready handshakes on input and output, and holds one transaction at a time.

Parameters:
WIDTH, 4, magnitude width in bits. The result is WIDTH+1 bits wide, so −(2^WIDTH − 1) is representable.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
in_valid  input  1  mag/neg valid
in_ready  output  1  block can accept an input this cycle
mag  input  WIDTH  unsigned magnitude
neg  input  1  1 means the value is −mag
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH+1  signed two's-complement value
busy  output  1  high in SHIFT or DONE

Behaviour:
- State machine: IDLE, SHIFT, DONE.
- Reset (async, any state, including mid-SHIFT):
  - state becomes IDLE; out_valid=0, result=0, busy=0.
  - Internal shift register, bit counter and carry are cleared.
  - in_ready=0 while rst is high; in_ready=1 on the first cycle after rst deasserts.
  - Any partial transaction is discarded.
- in_ready = (state==IDLE) && !rst, combinational from state.
- IDLE:
  - On in_valid && in_ready at edge E0: latch {1'b0, mag} into the operand register (zero-extended to WIDTH+1), latch neg, set carry=1, set count=0, go to SHIFT.
  - in_valid without acceptance has no effect.
- SHIFT, one bit per edge, edges E1..E(WIDTH+1):
  - Operand bit i = op[count].
  - If neg: out bit = ~op[i] XOR carry; carry_next = ~op[i] AND carry (full adder with b=0, i.e. invert and add 1).
  - If !neg: out bit = op[i]; carry unused.
  - The out bit shifts into the result register from the MSB side (shift right); count increments.
  - At edge E(WIDTH+1), with the last bit processed: go to DONE and set out_valid=1.
  - Final carry is discarded.
  - Inputs are ignored throughout SHIFT (in_ready=0).
- Latency: out_valid first high in the cycle following edge E(WIDTH+1), i.e. WIDTH+1 clocks after acceptance. For WIDTH=4 that is 5 clocks.
- DONE:
  - result and out_valid are held stable while out_ready=0, for any number of cycles.
  - On out_valid && out_ready at an edge: out_valid=0, go to IDLE. result keeps its value until the next SHIFT begins overwriting it.
  - in_ready rises in the cycle after the output transfer; there is no same-cycle turnaround.
- result changes only while in SHIFT; it is meaningful only when out_valid=1.
- Boundaries:
  - mag=0 with neg=1 (negative zero) gives result 0; the carry ripples out and is dropped.
  - mag=2^WIDTH−1 with neg=1 gives the minimum value 1 followed by WIDTH−1 zeros and a 1 (for WIDTH=4: 5'b10001). No overflow is possible.
  - neg=0 gives result = zero-extended mag.
- Throughput: at best one result per WIDTH+3 cycles (accept, WIDTH+1 shift cycles, DONE transfer).
- Counter width is clog2(WIDTH+2). Count saturation and wrap never occur, because the state leaves SHIFT at count==WIDTH.

Test Plan:
- mag=4'd5, neg=0, out_ready=1 → in_ready drops the cycle after acceptance; out_valid high 5 clocks after acceptance with result=5'b00101; in_ready=1 the cycle after transfer.
- mag=4'd5, neg=1 → result=5'b11011 (−5). Also mag=4'd15, neg=1 → result=5'b10001 (−15).
- mag=0, neg=1 → result=5'b00000. mag=0, neg=0 → 5'b00000.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid → result and out_valid stable, in_ready=0, a new in_valid is ignored; then out_ready=1 → transfer in 1 cycle, IDLE next.
- rst pulsed asynchronously at edge E3 of a neg=1 transaction → out_valid=0, result=0, busy=0 immediately. After release, mag=4'd9, neg=1 → result=5'b10111 (−9), with no residue from the aborted transaction.
- Sweep all 32 (mag,neg) pairs back-to-back with random out_ready → every result equals neg ? −mag : mag, sign-extended to 5 bits, in order.
